xge_tx_arbiter: RTL and testbench

//  Shares the single xge_mac packet-transmit interface (pkt_tx_*) between N_PORTS

---
 rtl/xge_arb_pkg.sv | 17 +
 rtl/xge_tx_arbiter_rr_pick.sv | 35 +++
 rtl/xge_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_xge_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xge_arb_pkg.sv
// Shared types for the xge_mac transmit arbiter.
//   arb_state_t : arbiter FSM state
//   BEAT_CNT_W  : width of the per-frame beat counter (MAX_BEATS must fit)
//   pkt_mod_t   : valid-byte count on an EOP beat (0 = all 8 bytes)
package xge_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_XFER    = 2'd1,
    ARB_DISCARD = 2'd2
  } arb_state_t;

  localparam int BEAT_CNT_W = 8;

  typedef logic [2:0] pkt_mod_t;

endpackage

// File: rtl/xge_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index of the last winner; search starts at ptr+1 and wraps
//   win_oh  : one-hot winner (0 when no request)
//   win_idx : winner index (0 when no request)
//   win_any : at least one request present
module rr_pick #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [PW-1:0] win_idx,
  output logic          win_any
);

  logic [PW-1:0] idx;

  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    idx     = '0;
    // First hit after ptr wins; later hits are masked by win_any.
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!win_any && req[idx]) begin
        win_any = 1'b1;
        win_idx = idx;
      end
    end
    win_oh = win_any ? (N'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/xge_tx_arbiter.sv
// Frame-atomic round-robin arbiter in front of the xge_mac pkt_tx interface.
// Ports:
//   clk_156m25, reset_156m25_n       : clock, synchronous active-low reset
//   in_val/in_sop/in_eop/in_mod/in_data : per-requester beat (port i at slice i)
//   in_rdy                           : per-requester beat accept
//   grant                            : one-hot current owner, 0 when idle
//   pkt_tx_*                         : registered beat to xge_mac (1-cycle lag)
//   pkt_tx_full                      : MAC back-pressure
//   trunc_cnt                        : saturating watchdog-truncation count
//   frame_cnt                        : wrapping count of EOPs emitted
module xge_tx_arbiter
  import xge_arb_pkg::*;
#(
  parameter int N_PORTS   = 4,
  parameter int MAX_BEATS = 190
) (
  input  logic                    clk_156m25,
  input  logic                    reset_156m25_n,
  input  logic [N_PORTS-1:0]      in_val,
  input  logic [N_PORTS-1:0]      in_sop,
  input  logic [N_PORTS-1:0]      in_eop,
  input  logic [3*N_PORTS-1:0]    in_mod,
  input  logic [64*N_PORTS-1:0]   in_data,
  output logic [N_PORTS-1:0]      in_rdy,
  output logic [N_PORTS-1:0]      grant,
  output logic [63:0]             pkt_tx_data,
  output logic                    pkt_tx_val,
  output logic                    pkt_tx_sop,
  output logic                    pkt_tx_eop,
  output logic [2:0]              pkt_tx_mod,
  input  logic                    pkt_tx_full,
  output logic [15:0]             trunc_cnt,
  output logic [31:0]             frame_cnt
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  // Beat counter holds beats already accepted, so the MAX_BEATS-th beat
  // arrives while the counter reads MAX_BEATS-1.
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BEATS - 1);

  arb_state_t            state;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         widx;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  logic [N_PORTS-1:0]    pick_oh;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;

  logic [63:0]           sel_data;
  pkt_mod_t              sel_mod;
  logic                  acc;

  // Only ports presenting a frame start are eligible, so a port stuck
  // mid-frame after a reset cannot grab the MAC.
  rr_pick #(.N(N_PORTS)) u_pick (
    .req     (in_val & in_sop),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_any (pick_any)
  );

  assign sel_data = in_data[int'(widx)*64 +: 64];
  assign sel_mod  = in_mod[int'(widx)*3 +: 3];
  assign acc      = (state == ARB_XFER) && !pkt_tx_full && in_val[widx];

  // DISCARD drains the owner regardless of MAC back-pressure.
  always_comb begin
    in_rdy = '0;
    case (state)
      ARB_XFER:    in_rdy = pkt_tx_full ? '0 : grant;
      ARB_DISCARD: in_rdy = grant;
      default:     in_rdy = '0;
    endcase
  end

  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state       <= ARB_IDLE;
      ptr         <= PW'(N_PORTS - 1);
      widx        <= '0;
      beat_cnt    <= '0;
      grant       <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
      trunc_cnt   <= '0;
      frame_cnt   <= '0;
    end else begin
      // Output register is zeroed unless a beat is accepted this cycle.
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant    <= pick_oh;
            widx     <= pick_idx;
            ptr      <= pick_idx;
            beat_cnt <= '0;
            state    <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (acc) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_data <= sel_data;
            pkt_tx_sop  <= in_sop[widx];
            beat_cnt    <= beat_cnt + 1'b1;
            if (in_eop[widx]) begin
              pkt_tx_eop <= 1'b1;
              pkt_tx_mod <= sel_mod;
              frame_cnt  <= frame_cnt + 1'b1;
              grant      <= '0;
              state      <= ARB_IDLE;
            end else if (beat_cnt == LAST_BEAT) begin
              // Runaway frame: close it on the wire, swallow the rest.
              pkt_tx_eop <= 1'b1;
              pkt_tx_mod <= '0;
              frame_cnt  <= frame_cnt + 1'b1;
              if (trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 1'b1;
              state      <= ARB_DISCARD;
            end else begin
              pkt_tx_mod <= sel_mod;
            end
          end
        end
        ARB_DISCARD: begin
          if (in_val[widx] && in_eop[widx]) begin
            grant <= '0;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_tx_arbiter.sv
module tb_xge_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 190;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_val, in_sop, in_eop, in_rdy, grant;
  logic [3*N-1:0]  in_mod;
  logic [64*N-1:0] in_data;
  logic [63:0]     pkt_tx_data;
  logic            pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full;
  logic [2:0]      pkt_tx_mod;
  logic [15:0]     trunc_cnt;
  logic [31:0]     frame_cnt;

  always #5 clk = ~clk;

  xge_tx_arbiter #(.N_PORTS(N), .MAX_BEATS(MAXB)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .in_val         (in_val),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_mod         (in_mod),
    .in_data        (in_data),
    .in_rdy         (in_rdy),
    .grant          (grant),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_full    (pkt_tx_full),
    .trunc_cnt      (trunc_cnt),
    .frame_cnt      (frame_cnt)
  );

  int         checks = 0;
  int         errors = 0;
  beat_t      src_q [N][$];
  beat_t      exp_q [$];
  int         mptr;
  int         exp_frames;
  int         exp_trunc;
  int         pcyc;
  int         first_val_n;
  logic [N-1:0] grant_at2;
  bit         prev_full;
  bit         prev_eop;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_src();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Each requester presents the head of its queue whenever it has one.
  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        in_val[i] = 1'b1;
        in_sop[i] = b.sop;
        in_eop[i] = b.eop;
        in_mod[3*i +: 3]   = b.mod;
        in_data[64*i +: 64] = b.data;
      end else begin
        in_val[i] = 1'b0;
        in_sop[i] = 1'b0;
        in_eop[i] = 1'b0;
        in_mod[3*i +: 3]   = '0;
        in_data[64*i +: 64] = '0;
      end
    end
  endtask

  // Stray sop on non-first beats must be passed through untouched.
  task automatic add_frame(input int port, input int len, input logic [2:0] last_mod);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = {$urandom, $urandom};
      b.sop  = (j == 0) || ($urandom_range(15) == 0);
      b.eop  = (j == len - 1);
      b.mod  = (j == len - 1) ? last_mod : 3'($urandom_range(7));
      src_q[port].push_back(b);
    end
  endtask

  // Reference: with every loaded requester always offering its next frame,
  // the wire carries whole frames chosen round-robin after the last winner,
  // each cut to MAXB beats (last kept one forced to eop, mod 0).
  task automatic build_expected();
    beat_t cp [N][$];
    beat_t b;
    int    win, n;
    bit    found, done;
    for (int i = 0; i < N; i++) cp[i] = src_q[i];
    forever begin
      found = 1'b0;
      win   = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && cp[(mptr + k) % N].size() > 0) begin
          found = 1'b1;
          win   = (mptr + k) % N;
        end
      end
      if (!found) break;
      mptr = win;
      n    = 0;
      done = 1'b0;
      while (!done) begin
        b = cp[win].pop_front();
        n++;
        if (b.eop) begin
          exp_q.push_back(b);
          done = 1'b1;
        end else if (n == MAXB) begin
          b.eop = 1'b1;
          b.mod = 3'd0;
          exp_q.push_back(b);
          exp_trunc++;
          while (!cp[win].pop_front().eop) ;
          done = 1'b1;
        end else begin
          exp_q.push_back(b);
        end
      end
      exp_frames++;
    end
  endtask

  // One clock: observe at negedge, then advance sources just after posedge.
  task automatic run_cycle(input bit full_next);
    logic [N-1:0] fire;
    beat_t        e;
    @(negedge clk);
    pcyc++;
    chk("grant_onehot", $onehot0(grant), 1);
    chk("rdy_outside_grant", in_rdy & ~grant, 0);
    if (prev_full) chk("val_after_full", pkt_tx_val, 0);
    if (prev_eop)  chk("idle_bubble", pkt_tx_val, 0);
    if (pkt_tx_val) begin
      if (first_val_n < 0) first_val_n = pcyc;
      if (exp_q.size() == 0) chk("extra_beat", pkt_tx_val, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat", {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, e);
      end
    end else begin
      chk("idle_zero", {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
    end
    if (pcyc == 2) grant_at2 = grant;
    prev_full = pkt_tx_full;
    prev_eop  = pkt_tx_val & pkt_tx_eop;
    fire      = in_val & in_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    pkt_tx_full = full_next;
    drive();
  endtask

  task automatic run_phase(input int full_pct, input int ff, input int ft, input int budget);
    bit f;
    build_expected();
    pcyc = 0;
    first_val_n = -1;
    drive();
    while ((exp_q.size() > 0 || any_src()) && pcyc < budget) begin
      f = ((pcyc + 1 >= ff) && (pcyc + 1 <= ft)) || ($urandom_range(99) < full_pct);
      run_cycle(f);
    end
    if (pcyc >= budget) begin
      chk("timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      for (int i = 0; i < N; i++) src_q[i].delete();
      drive();
    end
    repeat (3) run_cycle(1'b0);
    chk("grant_idle", grant, 0);
    chk("frame_cnt", frame_cnt, exp_frames);
    chk("trunc_cnt", trunc_cnt, exp_trunc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_val = '0; in_sop = '0; in_eop = '0; in_mod = '0; in_data = '0;
    pkt_tx_full = 1'b0;
    mptr = N - 1; exp_frames = 0; exp_trunc = 0;
    prev_full = 1'b0; prev_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_val", pkt_tx_val, 0);
    chk("rst_beat", {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_trunc_cnt", trunc_cnt, 0);
    chk("rst_in_rdy", in_rdy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 3-beat frame on port 0; in_val seen on cycle 1, grant on 2,
    // first wire beat on 3 (two cycles after in_val).
    add_frame(0, 3, 3'd4);
    run_phase(0, 0, -1, 100);
    chk("t1_grant", grant_at2, 4'b0001);
    chk("t1_latency", first_val_n, 3);

    // All ports, two 2-beat frames each.
    for (int p = 0; p < N; p++) begin
      add_frame(p, 2, 3'($urandom_range(7)));
      add_frame(p, 2, 3'($urandom_range(7)));
    end
    run_phase(0, 0, -1, 200);

    // Back-pressure for 5 cycles mid-frame.
    add_frame(1, 12, 3'd5);
    run_phase(0, 5, 9, 200);

    // Runaway 200-beat frame followed by a normal one.
    add_frame(2, 200, 3'd3);
    add_frame(2, 3, 3'd6);
    run_phase(0, 0, -1, 1000);

    // Exactly MAXB beats: normal end.
    add_frame(3, MAXB, 3'd2);
    run_phase(10, 0, -1, 1000);

    // Randomised mixes with random back-pressure.
    repeat (4) begin
      for (int p = 0; p < N; p++) begin
        int nf = $urandom_range(0, 3);
        for (int k = 0; k < nf; k++)
          add_frame(p, ($urandom_range(19) == 0) ? 195 : $urandom_range(1, 16),
                    3'($urandom_range(7)));
      end
      run_phase(30, 0, -1, 4000);
    end

    // Reset during beat 5 of a port-2 frame.
    add_frame(2, 10, 3'd1);
    build_expected();
    pcyc = 0;
    first_val_n = -1;
    drive();
    while (src_q[2].size() > 6 && pcyc < 50) run_cycle(1'b0);
    chk("t6_reach_beat5", src_q[2].size(), 6);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    drive();
    mptr = N - 1; exp_frames = 0; exp_trunc = 0;
    prev_full = 1'b0; prev_eop = 1'b0;
    chk("t6_grant", grant, 0);
    chk("t6_val", pkt_tx_val, 0);
    chk("t6_beat", {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
    chk("t6_trunc_cnt", trunc_cnt, 0);
    chk("t6_in_rdy", in_rdy, 0);
    for (int p = N - 1; p >= 0; p--) add_frame(p, 3, 3'($urandom_range(7)));
    run_phase(0, 0, -1, 200);
    chk("t6_port0_first", grant_at2, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
